// File: rtl/bnn_pkg.sv
// Shared definitions for the BNN accelerator front end: frame geometry,
// feeder state encoding and a small sizing helper.
package bnn_pkg;

    // Default frame geometry (28x28 grayscale digit)
    localparam int IMG_W_DEF  = 28;
    localparam int IMG_H_DEF  = 28;
    localparam int IMG_PIXELS = IMG_W_DEF * IMG_H_DEF;

    // Counter wide enough to index every pixel of the default frame
    localparam int CNT_W = $clog2(IMG_PIXELS);

    // Raw state codes, kept as plain constants for legacy netlists and
    // waveform scripts that decode the state register numerically.
    localparam logic [1:0] FS_IDLE   = 2'd0;
    localparam logic [1:0] FS_LOAD   = 2'd1;
    localparam logic [1:0] FS_STREAM = 2'd2;
    localparam logic [1:0] FS_DONE   = 2'd3;

    typedef enum logic [1:0] {
        IDLE   = FS_IDLE,
        LOAD   = FS_LOAD,
        STREAM = FS_STREAM,
        DONE   = FS_DONE
    } feeder_state_t;

    // Address width for a table of n entries; never returns zero so a
    // degenerate 1-pixel frame still gets a legal 1-bit counter.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/frame_bitbuf.sv
// One-bit-per-pixel frame store. Single synchronous write port, single
// combinational read port. Contents are deliberately not reset: the frame
// is always fully rewritten by a LOAD before it is streamed.
import bnn_pkg::*;

module frame_bitbuf #(
    parameter int DEPTH = IMG_PIXELS,
    parameter int AW    = CNT_W
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic          wbit,
    input  logic [AW-1:0] raddr,
    output logic          rbit
);

    logic mem_q [DEPTH];

    // Write port: store one binarized pixel per accepted handshake
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wbit;
        end
    end

    // Read port is purely combinational so the streamer sees a freshly
    // written bit in the same cycle its address is presented.
    assign rbit = mem_q[raddr];

endmodule

// File: rtl/img_bin_feeder.sv
// Frame feeder for the BNN accelerator. Accepts a full frame of grayscale
// pixels through a valid/ready handshake at whatever rate the host manages,
// binarizes each pixel against a fixed threshold, and then replays the whole
// frame as a gap-free 1-bit stream with top_start held high, since the
// accelerator cannot stall its image input.
//
// state  | meaning
// -------+------------------------------------------------------------
// IDLE   | waiting for start; no pixels accepted
// LOAD   | s_ready high; each handshake writes one bit to the buffer
// STREAM | top_start high; one buffered bit per cycle on image_in
// DONE   | single-cycle frame_done pulse, then back to IDLE
import bnn_pkg::*;

module img_bin_feeder #(
    parameter int IMG_W  = 28,
    parameter int IMG_H  = 28,
    parameter int PIX_W  = 8,
    parameter int THRESH = 127
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic [PIX_W-1:0] s_pix,
    input  logic             s_valid,
    output logic             s_ready,
    output logic             image_in,
    output logic             top_start,
    output logic             busy,
    output logic             frame_done
);

    localparam int               FRAME_PIX = IMG_W * IMG_H;
    localparam int               CW        = cnt_width(FRAME_PIX);
    localparam logic [CW-1:0]    LAST      = CW'(FRAME_PIX - 1);
    localparam logic [PIX_W-1:0] THRESH_V  = PIX_W'(THRESH);

    feeder_state_t state_q, state_d;
    logic [CW-1:0] pix_cnt_q, pix_cnt_d;
    logic [CW-1:0] out_cnt_q, out_cnt_d;

    // Output registers, loaded from the next state so each output is valid
    // in the very cycle its state begins.
    logic s_ready_q, s_ready_d;
    logic top_start_q, top_start_d;
    logic busy_q, busy_d;
    logic frame_done_q, frame_done_d;

    logic handshake;
    logic pix_bit;
    logic buf_we;
    logic buf_rbit;

    // s_ready_q is high exactly while in LOAD, so the handshake never
    // depends combinationally on anything but registered state and s_valid.
    assign handshake = s_valid & s_ready_q;

    // Unsigned strict comparison: THRESH itself maps to 0
    assign pix_bit = (s_pix > THRESH_V);

    frame_bitbuf #(
        .DEPTH (FRAME_PIX),
        .AW    (CW)
    ) u_bitbuf (
        .clk   (clk),
        .we    (buf_we),
        .waddr (pix_cnt_q),
        .wbit  (pix_bit),
        .raddr (out_cnt_q),
        .rbit  (buf_rbit)
    );

    // Next-state, counter and buffer-write decode
    always_comb begin
        state_d   = state_q;
        pix_cnt_d = pix_cnt_q;
        out_cnt_d = out_cnt_q;
        buf_we    = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = LOAD;
                end
            end
            LOAD: begin
                if (handshake) begin
                    buf_we = 1'b1;
                    if (pix_cnt_q == LAST) begin
                        state_d   = STREAM;
                        pix_cnt_d = '0;
                    end else begin
                        pix_cnt_d = pix_cnt_q + 1'b1;
                    end
                end
            end
            STREAM: begin
                if (out_cnt_q == LAST) begin
                    state_d   = DONE;
                    out_cnt_d = '0;
                end else begin
                    out_cnt_d = out_cnt_q + 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Abort overrides everything, including a write on the same cycle,
        // so a half-loaded frame is simply left behind in the buffer.
        if (abort) begin
            state_d   = IDLE;
            pix_cnt_d = '0;
            out_cnt_d = '0;
            buf_we    = 1'b0;
        end
    end

    // Output register next values follow the state being entered
    always_comb begin
        s_ready_d    = (state_d == LOAD);
        top_start_d  = (state_d == STREAM);
        busy_d       = (state_d != IDLE);
        frame_done_d = (state_d == DONE);
    end

    // State, counters and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            pix_cnt_q    <= '0;
            out_cnt_q    <= '0;
            s_ready_q    <= 1'b0;
            top_start_q  <= 1'b0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            pix_cnt_q    <= pix_cnt_d;
            out_cnt_q    <= out_cnt_d;
            s_ready_q    <= s_ready_d;
            top_start_q  <= top_start_d;
            busy_q       <= busy_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign s_ready    = s_ready_q;
    assign top_start  = top_start_q;
    assign busy       = busy_q;
    assign frame_done = frame_done_q;

    // Gate the buffer read so image_in is 0 everywhere outside STREAM
    assign image_in   = top_start_q & buf_rbit;

endmodule

// File: tb/tb_img_bin_feeder.sv
// Directed bench for img_bin_feeder: a table of threshold vectors cycled
// through a full frame, plus hand-built sequences for bursty loading,
// ignored start pulses, abort during LOAD and reset during STREAM.
module tb_img_bin_feeder;

    localparam int NPIX = 784;
    localparam int NVEC = 12;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       abort;
    logic [7:0] s_pix;
    logic       s_valid;
    logic       s_ready;
    logic       image_in;
    logic       top_start;
    logic       busy;
    logic       frame_done;

    always #5 clk = ~clk;

    img_bin_feeder #(
        .IMG_W  (28),
        .IMG_H  (28),
        .PIX_W  (8),
        .THRESH (127)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .abort      (abort),
        .s_pix      (s_pix),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .image_in   (image_in),
        .top_start  (top_start),
        .busy       (busy),
        .frame_done (frame_done)
    );

    typedef struct {
        logic [7:0] pix;
        logic       exp_bit;
    } vec_t;

    vec_t       vecs [NVEC];
    logic [7:0] pix_arr  [NPIX];
    logic       exp_bits [NPIX];
    logic       got_bits [NPIX];

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, req);
        end
    endtask

    task automatic fill_table();
        for (int i = 0; i < NPIX; i++) begin
            pix_arr[i]  = vecs[i % NVEC].pix;
            exp_bits[i] = vecs[i % NVEC].exp_bit;
        end
    endtask

    // Even indices get (ev_pix, ev_bit), odd indices get (od_pix, od_bit)
    task automatic fill_alt(input logic [7:0] ev_pix, input logic [7:0] od_pix,
                            input logic ev_bit, input logic od_bit);
        for (int i = 0; i < NPIX; i++) begin
            pix_arr[i]  = (i % 2 == 0) ? ev_pix : od_pix;
            exp_bits[i] = (i % 2 == 0) ? ev_bit : od_bit;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            start   = 1'b0;
            abort   = 1'b0;
            rst     = 1'b0;
            s_valid = 1'b0;
            s_pix   = 8'h00;
        end
    endtask

    // One frame: start pulse in cycle 0, pixels offered from cycle 1 on
    // (every cycle, or only when k % gap == 1). Optional injections: abort
    // when abort_at pixels are accepted, rst when rst_at bits have been
    // streamed, and stray start pulses during LOAD / STREAM.
    task automatic run_frame(input string tag, input int gap, input int abort_at,
                             input int rst_at, input int ld_start_at, input int st_start_at);
        int k        = 0;
        int idx      = 0;
        int out_idx  = 0;
        int sready_n = 0;
        int ts_n     = 0;
        int done_n   = 0;
        int first_ts = -1;
        int last_ts  = -1;
        int last_acc = -1;
        int done_k   = -1;
        int busy_bad = 0;
        int img_bad  = 0;
        int bit_bad  = 0;
        int first_bad = -1;
        int inj_k    = -1;
        bit inj_rst  = 1'b0;
        bit ld_fired = 1'b0;
        bit st_fired = 1'b0;
        bit fin      = 1'b0;
        int exp_last;
        int limit;

        exp_last = (gap <= 1) ? NPIX : gap * (NPIX - 1) + 1;
        limit    = exp_last + NPIX + 50;
        for (int i = 0; i < NPIX; i++) got_bits[i] = 1'b0;

        @(posedge clk);
        #1;
        start   = 1'b1;
        abort   = 1'b0;
        rst     = 1'b0;
        s_valid = 1'b0;
        s_pix   = 8'h00;
        @(negedge clk);
        chk($sformatf("%s busy_in_start_cycle", tag), busy, 0);

        while (!fin) begin
            @(posedge clk);
            #1;
            k++;
            start   = 1'b0;
            abort   = 1'b0;
            rst     = 1'b0;
            s_valid = (idx < NPIX) && (gap <= 1 || (k % gap) == 1);
            s_pix   = (idx < NPIX) ? pix_arr[idx] : 8'h00;
            if (!ld_fired && ld_start_at >= 0 && idx == ld_start_at) begin
                start    = 1'b1;
                ld_fired = 1'b1;
            end
            if (!st_fired && st_start_at > 0 && out_idx == st_start_at) begin
                start    = 1'b1;
                st_fired = 1'b1;
            end
            if (inj_k < 0 && abort_at >= 0 && idx == abort_at) begin
                abort = 1'b1;
                inj_k = k;
            end
            if (inj_k < 0 && rst_at > 0 && out_idx == rst_at) begin
                rst     = 1'b1;
                inj_k   = k;
                inj_rst = 1'b1;
            end
            @(negedge clk);

            if (inj_k >= 0 && k == inj_k + 1) begin
                chk($sformatf("%s busy_after_inject", tag), busy, 0);
                chk($sformatf("%s s_ready_after_inject", tag), s_ready, 0);
                chk($sformatf("%s top_start_after_inject", tag), top_start, 0);
                chk($sformatf("%s image_in_after_inject", tag), image_in, 0);
                fin = 1'b1;
            end else begin
                if (s_valid && s_ready && inj_k < 0) begin
                    last_acc = k;
                    idx++;
                end
                if (s_ready) sready_n++;
                if (done_k < 0 && !busy) busy_bad++;
                if (top_start) begin
                    if (first_ts < 0) first_ts = k;
                    last_ts = k;
                    ts_n++;
                    if (out_idx < NPIX) begin
                        got_bits[out_idx] = image_in;
                        if (image_in !== exp_bits[out_idx]) begin
                            bit_bad++;
                            if (first_bad < 0) first_bad = out_idx;
                        end
                        out_idx++;
                    end
                end else if (image_in !== 1'b0) begin
                    img_bad++;
                end
                if (frame_done) begin
                    done_n++;
                    if (done_k < 0) done_k = k;
                end else if (done_k >= 0) begin
                    chk($sformatf("%s busy_after_done", tag), busy, 0);
                    chk($sformatf("%s s_ready_after_done", tag), s_ready, 0);
                    fin = 1'b1;
                end
                if (!fin && k > limit) begin
                    chk($sformatf("%s frame_end_cycle_budget", tag), k, limit);
                    fin = 1'b1;
                end
            end
        end

        if (inj_k < 0) begin
            chk($sformatf("%s frame_done_pulses", tag), done_n, 1);
            chk($sformatf("%s start_to_done_cycles", tag), done_k + 1, exp_last + NPIX + 2);
            chk($sformatf("%s s_ready_cycles", tag), sready_n, exp_last);
            chk($sformatf("%s last_accept_cycle", tag), last_acc, exp_last);
            chk($sformatf("%s top_start_cycles", tag), ts_n, NPIX);
            chk($sformatf("%s stream_span", tag), last_ts - first_ts + 1, NPIX);
            chk($sformatf("%s first_bit_cycle", tag), first_ts, exp_last + 1);
            chk($sformatf("%s bit_errors(first %0d)", tag, first_bad), bit_bad, 0);
            chk($sformatf("%s busy_low_cycles", tag), busy_bad, 0);
            chk($sformatf("%s image_in_outside_stream", tag), img_bad, 0);
        end else if (inj_rst) begin
            chk($sformatf("%s bits_before_reset", tag), ts_n, rst_at + 1);
            chk($sformatf("%s bit_errors_before_reset", tag), bit_bad, 0);
        end else begin
            chk($sformatf("%s no_stream_before_abort", tag), ts_n, 0);
            chk($sformatf("%s busy_low_before_abort", tag), busy_bad, 0);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int bad;

        vecs[0]  = '{8'd127, 1'b0};
        vecs[1]  = '{8'd128, 1'b1};
        vecs[2]  = '{8'd255, 1'b1};
        vecs[3]  = '{8'd0,   1'b0};
        vecs[4]  = '{8'd126, 1'b0};
        vecs[5]  = '{8'd129, 1'b1};
        vecs[6]  = '{8'd254, 1'b1};
        vecs[7]  = '{8'd10,  1'b0};
        vecs[8]  = '{8'd1,   1'b0};
        vecs[9]  = '{8'd200, 1'b1};
        vecs[10] = '{8'd192, 1'b1};
        vecs[11] = '{8'd64,  1'b0};

        rst     = 1'b1;
        start   = 1'b0;
        abort   = 1'b0;
        s_valid = 1'b0;
        s_pix   = 8'h00;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset s_ready", s_ready, 0);
        chk("reset top_start", top_start, 0);
        chk("reset busy", busy, 0);
        chk("reset frame_done", frame_done, 0);
        chk("reset image_in", image_in, 0);

        // Pixels offered in IDLE must be ignored and not advance the write index
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            rst     = 1'b0;
            s_valid = 1'b1;
            s_pix   = 8'd255;
            @(negedge clk);
            chk($sformatf("idle s_ready %0d", i), s_ready, 0);
            chk($sformatf("idle busy %0d", i), busy, 0);
        end
        idle(1);

        // Table frame with stray start pulses during LOAD and STREAM
        fill_table();
        run_frame("tbl", 1, -1, -1, 300, 300);
        for (int j = 0; j < NVEC; j++) begin
            bad = 0;
            for (int i = j; i < NPIX; i += NVEC) begin
                if (got_bits[i] !== vecs[j].exp_bit) bad++;
            end
            chk($sformatf("thr pix=%0d wrong_bits", vecs[j].pix), bad, 0);
        end
        idle(2);

        fill_alt(8'd127, 8'd128, 1'b0, 1'b1);
        run_frame("sweep", 1, -1, -1, -1, -1);
        idle(2);

        fill_alt(8'd10, 8'd200, 1'b0, 1'b1);
        run_frame("burst", 3, -1, -1, -1, -1);
        idle(2);

        fill_alt(8'd255, 8'd255, 1'b1, 1'b1);
        run_frame("abort", 1, 400, -1, -1, -1);
        idle(2);

        fill_alt(8'd255, 8'd0, 1'b1, 1'b0);
        run_frame("post_abort", 1, -1, -1, -1, -1);
        idle(2);

        fill_table();
        run_frame("rst", 1, -1, 300, -1, -1);
        idle(2);

        fill_alt(8'd128, 8'd127, 1'b1, 1'b0);
        run_frame("post_rst", 2, -1, -1, -1, -1);
        idle(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/img_bin_feeder.md
# img_bin_feeder

Upstream feeder for the BNN accelerator top. It accepts 8-bit grayscale pixels from a bursty source through a valid/ready handshake and binarizes each one against a threshold. It stores the full 28x28 frame as 784 bits, then drives the accelerator's `image_in`/`start` pair with one bit per cycle on consecutive cycles. This decouples a stalling host or DMA from the accelerator, which has no backpressure on its image input.

## Interface
Parameters:
- `IMG_W`, 28, image width in pixels
- `IMG_H`, 28, image height in pixels
- `PIX_W`, 8, input pixel width
- `THRESH`, 127, binarization threshold; a pixel produces bit 1 when it is strictly greater than `THRESH`

Ports (one clock; reset is synchronous and active-high):
- `clk` input 1: sole clock, rising edge
- `rst` input 1: synchronous active-high reset
- `start` input 1: single-cycle request to load a new frame; honoured only in IDLE
- `abort` input 1: synchronous return to IDLE from any state
- `s_pix` input PIX_W: pixel data, row-major order
- `s_valid` input 1: `s_pix` is valid
- `s_ready` output 1: the block accepts a pixel this cycle
- `image_in` output 1: binarized pixel stream to the accelerator
- `top_start` output 1: accelerator start; high throughout STREAM
- `busy` output 1: high in any state other than IDLE
- `frame_done` output 1: one-cycle pulse after the last bit is streamed

## Operation
- Reset or `abort`: state goes to IDLE and both counters clear. All outputs become 0 on the next edge. Buffer contents are not cleared. If reset and abort are asserted together, reset wins; the result is identical.
- **IDLE**
  - `s_ready` = 0.
  - When `start` = 1, go to LOAD.
- **LOAD**
  - `s_ready` = 1.
  - On each handshake (`s_valid & s_ready`), write `buf[pix_cnt] = (s_pix > THRESH)` and increment `pix_cnt`.
  - The handshake at `pix_cnt == IMG_W*IMG_H-1` moves the state to STREAM and clears `pix_cnt`.
  - Cycles with `s_valid` = 0 leave the state unchanged and are allowed without limit.
- **STREAM**
  - `s_ready` = 0, `top_start` = 1, `image_in = buf[out_cnt]`.
  - `out_cnt` increments every cycle unconditionally.
  - At `out_cnt == IMG_W*IMG_H-1`, go to DONE and clear `out_cnt`.
- **DONE**
  - `frame_done` = 1 for exactly one cycle, `top_start` = 0, `image_in` = 0.
  - Next state is IDLE.
- `start` outside IDLE is ignored.
- Pixels presented outside LOAD are not consumed.
- Counters are wide enough for `IMG_W*IMG_H-1`: 10 bits at the defaults. They never wrap, because both transitions clear them.
- The comparison is unsigned: `s_pix` = 128 gives 1, 127 gives 0, 255 gives 1, 0 gives 0.

## Timing
- `s_ready` is a registered function of state, so it is never combinationally dependent on `s_valid`.
- Latency:
  - The edge that accepts the last pixel is followed in the same cycle by state STREAM, with `image_in` = bit 0 and `top_start` = 1.
  - Bit k appears k cycles later.
- STREAM lasts exactly `IMG_W*IMG_H` cycles with no gaps; `top_start` is high for all of them.
- DONE occupies 1 cycle. IDLE is entered on the following cycle.
- The minimum cycles from `start` to `frame_done` is 1 + 784 + 784 + 1 with back-to-back `s_valid`.
- `busy` is high from the cycle after the accepted `start` through DONE, inclusive.

## Structure
- Shared package `bnn_pkg`:
  - `IMG_PIXELS` = `IMG_W*IMG_H` constant
  - `feeder_state_t` enum {IDLE, LOAD, STREAM, DONE}
  - counter width localparam `$clog2(IMG_PIXELS)`
- Sub-module `frame_bitbuf`: `IMG_PIXELS` x 1-bit storage with a single write port (`we`, `waddr`, `wbit`) and a single combinational read port (`raddr` → `rbit`). It has no reset.
- Top-level contents: the FSM, both counters, the threshold comparator and the output registers.

## Test plan
- **Threshold sweep:** a frame of alternating pixel values 127 and 128 → `image_in` toggles 0,1,0,1… for 784 cycles starting the cycle after the last accept.
- **Continuous load:** `start` pulse, then `s_valid` held high with 784 pixels all 255 → `s_ready` is high for exactly 784 cycles. `top_start` is high for exactly 784 cycles with `image_in` = 1 throughout. `frame_done` pulses exactly once, 1570 cycles after `start`.
- **Bursty source:** `s_valid` high one cycle in three, with pixel i = (i%2)?200:10 → the streamed bits match 0,1,0,1…. STREAM has no gaps. Total load time is about 2352 cycles.
- **Ignored inputs:** `start` pulsed mid-LOAD and mid-STREAM → no state change. `s_valid` in IDLE → `s_ready` = 0 and no write occurs.
- **Abort and reset mid-operation:** `abort` at pixel 400 → IDLE next cycle with `busy` = 0. A new `start` plus 784 pixels then streams only the new frame. A repeat using `rst` during STREAM → `top_start`, `image_in` and `busy` are 0 the cycle after.
